// File: rtl/mmio_uart_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mmio_uart_tx_pkg
//  Description : Shared constants and types for the memory-mapped UART
//                transmitter: register offsets, STATUS bit positions and
//                the transmit FSM state type.
//  Revision    : 1.0  initial release
// ============================================================================
package mmio_uart_tx_pkg;

    // Register offsets within the 16-byte window (address[3:0], word aligned)
    localparam logic [3:0] c_OFF_TXDATA = 4'h0;
    localparam logic [3:0] c_OFF_STATUS = 4'h4;
    localparam logic [3:0] c_OFF_DIV    = 4'h8;

    // STATUS register bit positions
    localparam int c_ST_BUSY    = 0;
    localparam int c_ST_FULL    = 1;
    localparam int c_ST_EMPTY   = 2;
    localparam int c_ST_OVF     = 3;
    localparam int c_ST_CNT_LSB = 8;

    // Serialiser states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tx_fifo
//  Description : Synchronous first-word-fall-through FIFO with push, pop,
//                full, empty and occupancy count. DEPTH must be a power of
//                two and at least 2. A push while full is accepted only when
//                a pop happens in the same cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Pointer and occupancy bookkeeping; pointers wrap naturally (power of two)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr] <= i_data;
    end

endmodule
`default_nettype wire

// File: rtl/mmio_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : mmio_uart_tx
//  Description : Memory-mapped 8N1 UART transmitter on the data-memory bus.
//                Registers: TXDATA (0x0), STATUS (0x4), DIV (0x8).
//                read_data is zero when not addressed so it can be OR-ed
//                with data-memory read data.
//                Build option MMIO_UART_TX_FIFO_EN: buffer is a FIFO of
//                FIFO_DEPTH entries; otherwise a single holding register.
//  Revision    : 1.0  initial release
// ============================================================================
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] DIV_RESET  = 16'd868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    input  logic        write_enable,
    input  logic [3:0]  write_mask,
    output logic [31:0] read_data,
    output logic        tx,
    output logic        irq
);

    tx_state_t   r_state;
    tx_state_t   w_state_next;
    logic [15:0] r_div;
    logic [15:0] r_cnt;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_shift;
    logic        r_ovf;

    logic        w_hit;
    logic [3:0]  w_off;
    logic        w_wr;
    logic        w_push;
    logic        w_pop;
    logic        w_bit_done;
    logic        w_busy;
    logic        w_ovf_set;
    logic        w_ovf_clr;
    logic        w_div_we;
    logic [15:0] w_div_new;
    logic [31:0] w_status;

    logic        w_buf_full;
    logic        w_buf_empty;
    logic [3:0]  w_buf_count;
    logic [7:0]  w_buf_data;

    logic        w_unused_ok;
    assign w_unused_ok = ^{address[1:0], write_data[31:16], write_mask[3:2]};

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    assign w_hit      = (address[31:4] == BASE_ADDR[31:4]);
    assign w_off      = {address[3:2], 2'b00};
    assign w_wr       = write_enable && w_hit;
    assign w_push     = w_wr && (w_off == c_OFF_TXDATA) && write_mask[0];
    assign w_ovf_clr  = w_wr && (w_off == c_OFF_STATUS) && write_mask[0]
                        && write_data[c_ST_OVF];
    assign w_div_we   = w_wr && (w_off == c_OFF_DIV) && (|write_mask[1:0]);
    assign w_div_new  = {write_mask[1] ? write_data[15:8] : r_div[15:8],
                         write_mask[0] ? write_data[7:0]  : r_div[7:0]};
    // A concurrent pop frees a slot, so only a push that cannot land overflows
    assign w_ovf_set  = w_push && w_buf_full && !w_pop;

    // ------------------------------------------------------------------
    // Transmit buffer
    // ------------------------------------------------------------------
`ifdef MMIO_UART_TX_FIFO_EN
    localparam int c_CW = $clog2(FIFO_DEPTH) + 1;
    logic [c_CW-1:0] w_fifo_count;

    tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (write_data[7:0]),
        .i_pop   (w_pop),
        .o_data  (w_buf_data),
        .o_full  (w_buf_full),
        .o_empty (w_buf_empty),
        .o_count (w_fifo_count)
    );

    assign w_buf_count = 4'(w_fifo_count);
`else
    localparam int c_unused_depth = FIFO_DEPTH;
    logic       r_hold_valid;
    logic [7:0] r_hold_data;

    // Single holding register; a push alongside a pop replaces the byte
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hold_valid <= 1'b0;
            r_hold_data  <= 8'h00;
        end else if (w_push && (!r_hold_valid || w_pop)) begin
            r_hold_valid <= 1'b1;
            r_hold_data  <= write_data[7:0];
        end else if (w_pop) begin
            r_hold_valid <= 1'b0;
        end
    end

    assign w_buf_full  = r_hold_valid;
    assign w_buf_empty = !r_hold_valid;
    assign w_buf_count = {3'b000, r_hold_valid};
    assign w_buf_data  = r_hold_data;
`endif

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    // DIV per-lane update (zero stored as one) and sticky overflow flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div <= DIV_RESET;
            r_ovf <= 1'b0;
        end else begin
            if (w_div_we) r_div <= (w_div_new == 16'h0000) ? 16'h0001 : w_div_new;
            if (w_ovf_set)      r_ovf <= 1'b1;
            else if (w_ovf_clr) r_ovf <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Serialiser FSM
    // ------------------------------------------------------------------
    assign w_bit_done = (r_cnt == 16'h0000);
    assign w_busy     = (r_state != IDLE);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_next;
    end

    // Next state and pop strobe; STOP chains straight into START when data waits
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_buf_empty) begin
                    w_state_next = START;
                    w_pop        = 1'b1;
                end
            end
            START: begin
                if (w_bit_done) w_state_next = DATA;
            end
            DATA: begin
                if (w_bit_done && (r_bit_idx == 3'd7)) w_state_next = STOP;
            end
            STOP: begin
                if (w_bit_done) begin
                    if (!w_buf_empty) begin
                        w_state_next = START;
                        w_pop        = 1'b1;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Bit timer and shift register; DIV is sampled only at bit boundaries
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt     <= 16'h0000;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'h00;
        end else if (w_pop) begin
            r_shift   <= w_buf_data;
            r_cnt     <= r_div - 1'b1;
            r_bit_idx <= 3'd0;
        end else if (r_state != IDLE) begin
            if (w_bit_done) begin
                r_cnt <= r_div - 1'b1;
                if (r_state == DATA) begin
                    r_shift   <= r_shift >> 1;
                    r_bit_idx <= r_bit_idx + 1'b1;
                end
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    // Line level follows state directly so reset forces it high at once
    always_comb begin
        case (r_state)
            START:   tx = 1'b0;
            DATA:    tx = r_shift[0];
            default: tx = 1'b1;
        endcase
    end

    assign irq = w_buf_empty && (r_state == IDLE);

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    // STATUS word assembly
    always_comb begin
        w_status                        = 32'h0;
        w_status[c_ST_BUSY]             = w_busy;
        w_status[c_ST_FULL]             = w_buf_full;
        w_status[c_ST_EMPTY]            = w_buf_empty;
        w_status[c_ST_OVF]              = r_ovf;
        w_status[c_ST_CNT_LSB +: 4]     = w_buf_count;
    end

    // Combinational load data, zero unless this window is addressed
    always_comb begin
        read_data = 32'h0;
        if (w_hit) begin
            case (w_off)
                c_OFF_STATUS: read_data = w_status;
                c_OFF_DIV:    read_data = {16'h0000, r_div};
                default:      read_data = 32'h0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mmio_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mmio_uart_tx
//  Description : Directed self-checking bench for mmio_uart_tx.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mmio_uart_tx;

    localparam logic [31:0] c_TXDATA = 32'h1000_0000;
    localparam logic [31:0] c_STATUS = 32'h1000_0004;
    localparam logic [31:0] c_DIV    = 32'h1000_0008;
    localparam logic [31:0] c_RSVD   = 32'h1000_000C;
`ifdef MMIO_UART_TX_FIFO_EN
    localparam logic [31:0] c_EXP_CNT6 = 32'd4;
`else
    localparam logic [31:0] c_EXP_CNT6 = 32'd1;
`endif

    logic        clk;
    logic        rst;
    logic [31:0] address;
    logic [31:0] write_data;
    logic        write_enable;
    logic [3:0]  write_mask;
    logic [31:0] read_data;
    logic        tx;
    logic        irq;

    logic [31:0] rd;
    int          n_tests;
    int          n_fail;

    mmio_uart_tx #(
        .BASE_ADDR  (32'h1000_0000),
        .FIFO_DEPTH (4),
        .DIV_RESET  (16'd868)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .address      (address),
        .write_data   (write_data),
        .write_enable (write_enable),
        .write_mask   (write_mask),
        .read_data    (read_data),
        .tx           (tx),
        .irq          (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        @(negedge clk);
        address      = a;
        write_data   = d;
        write_mask   = m;
        write_enable = 1'b1;
        @(posedge clk);
        #1;
        write_enable = 1'b0;
        write_mask   = 4'h0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = read_data;
    endtask

    function automatic logic exp_level(input logic [7:0] b, input int bit_n);
        if (bit_n == 0)      return 1'b0;
        else if (bit_n == 9) return 1'b1;
        else                 return b[bit_n-1];
    endfunction

    // Sample n is taken just after edge k+1+n, where k is the edge that accepted the store
    task automatic check_frames(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                                input int nfr, input int div, input int first);
        for (int n = first; n < nfr * 10 * div; n++) begin
            int   fr;
            int   bn;
            logic e;
            @(posedge clk);
            #1;
            fr = n / (10 * div);
            bn = (n % (10 * div)) / div;
            e  = exp_level((fr == 0) ? b0 : b1, bn);
            check($sformatf("%s_s%0d", tag, n), {31'b0, tx}, {31'b0, e});
        end
    endtask

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        rst          = 1'b0;
        address      = 32'h0;
        write_data   = 32'h0;
        write_enable = 1'b0;
        write_mask   = 4'h0;

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_low", {31'b0, tx}, 32'd1);
        check("rst_irq_low", {31'b0, irq}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        bus_read(c_STATUS, rd); check("rst_status", rd, 32'h0000_0004);
        bus_read(c_DIV, rd);    check("rst_div", rd, 32'd868);
        bus_read(c_TXDATA, rd); check("rst_txdata_rd", rd, 32'h0);
        bus_read(c_RSVD, rd);   check("rst_rsvd_rd", rd, 32'h0);

        // ---------------- single frame, DIV=4, 0x55 ----------------
        bus_write(c_DIV, 32'd4, 4'b0011);
        bus_read(c_DIV, rd); check("t1_div", rd, 32'd4);
        check("t1_irq_pre", {31'b0, irq}, 32'd1);
        bus_write(c_TXDATA, 32'h0000_0055, 4'b0001);
        check("t1_irq_fall", {31'b0, irq}, 32'd0);
        check("t1_tx_idle", {31'b0, tx}, 32'd1);
        check_frames("t1", 8'h55, 8'h00, 1, 4, 0);
        check("t1_irq_stop", {31'b0, irq}, 32'd0);
        @(posedge clk);
        #1;
        check("t1_irq_rise", {31'b0, irq}, 32'd1);
        check("t1_tx_end", {31'b0, tx}, 32'd1);

        // ---------------- back-to-back frames, DIV=2 ----------------
        bus_write(c_DIV, 32'd2, 4'b0011);
        bus_write(c_TXDATA, 32'h0000_00A1, 4'b0001);
        bus_write(c_TXDATA, 32'h0000_003C, 4'b0001);
        check("t2_s0", {31'b0, tx}, 32'd0);
        bus_read(c_STATUS, rd);
        check("t2_count", {28'b0, rd[11:8]}, 32'd1);
        check("t2_busy", {31'b0, rd[0]}, 32'd1);
        check_frames("t2", 8'hA1, 8'h3C, 2, 2, 1);
        @(posedge clk);
        #1;
        check("t2_irq_end", {31'b0, irq}, 32'd1);

        // ---------------- overflow ----------------
        for (int i = 1; i <= 6; i++) begin
            bus_write(c_TXDATA, 32'(i * 17), 4'b0001);
        end
        bus_read(c_STATUS, rd);
        check("t3_ovf_set", {31'b0, rd[3]}, 32'd1);
        check("t3_full", {31'b0, rd[1]}, 32'd1);
        check("t3_count", {28'b0, rd[11:8]}, c_EXP_CNT6);
        bus_write(c_STATUS, 32'h0000_0008, 4'b0001);
        bus_read(c_STATUS, rd);
        check("t3_ovf_clr", {31'b0, rd[3]}, 32'd0);
        begin
            int cyc;
            cyc = 0;
            while (irq !== 1'b1 && cyc < 1000) begin
                @(posedge clk);
                #1;
                cyc++;
            end
            check("t3_drain", {31'b0, irq}, 32'd1);
        end
        bus_read(c_STATUS, rd);
        check("t3_status_idle", rd, 32'h0000_0004);

        // ---------------- DIV=0 stored as 1, byte lanes, misses ----------------
        bus_write(c_DIV, 32'd0, 4'b0011);
        bus_read(c_DIV, rd); check("t4_div_zero", rd, 32'd1);
        bus_write(c_TXDATA, 32'h0000_00FF, 4'b0001);
        check_frames("t4", 8'hFF, 8'h00, 1, 1, 0);
        @(posedge clk);
        #1;
        check("t4_irq_end", {31'b0, irq}, 32'd1);
        bus_write(32'h2000_0000, 32'hFFFF_FFFF, 4'hF);
        bus_write(32'h2000_0008, 32'h0000_0055, 4'hF);
        bus_write(c_RSVD, 32'hFFFF_FFFF, 4'hF);
        bus_read(32'h2000_0000, rd); check("t4_miss_rd", rd, 32'h0);
        bus_read(32'h2000_0004, rd); check("t4_miss_rd_st", rd, 32'h0);
        bus_read(c_RSVD, rd);        check("t4_rsvd_rd", rd, 32'h0);
        check("t4_miss_irq", {31'b0, irq}, 32'd1);
        bus_read(c_DIV, rd);    check("t4_miss_div", rd, 32'd1);
        bus_read(c_STATUS, rd); check("t4_miss_status", rd, 32'h0000_0004);
        bus_write(c_DIV, 32'h0000_1234, 4'b0010);
        bus_read(c_DIV, rd); check("t4_div_lane1", rd, 32'h0000_1201);
        bus_write(c_DIV, 32'h0000_5634, 4'b0001);
        bus_read(c_DIV, rd); check("t4_div_lane0", rd, 32'h0000_1234);

        // ---------------- async reset mid-frame ----------------
        bus_write(c_DIV, 32'd8, 4'b0011);
        bus_write(c_TXDATA, 32'h0000_0000, 4'b0001);
        repeat (20) @(posedge clk);
        #2;
        check("t5_mid_data", {31'b0, tx}, 32'd0);
        rst = 1'b0;
        #1;
        check("t5_rst_tx", {31'b0, tx}, 32'd1);
        check("t5_rst_irq", {31'b0, irq}, 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        bus_read(c_STATUS, rd); check("t5_status", rd, 32'h0000_0004);
        bus_read(c_DIV, rd);    check("t5_div", rd, 32'd868);
        repeat (5) @(posedge clk);
        #1;
        check("t5_tx_quiet", {31'b0, tx}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
